// File: rtl/cpu_pkg.sv
// Shared CPU definitions: run states, opcodes, register-file geometry.
package cpu_pkg;
  typedef enum logic {
    idle = 1'b0,
    exec = 1'b1
  } cpu_state_e;

  localparam int GR_AW  = 3;
  localparam int NGR    = 1 << GR_AW;
  localparam int DW_DEF = 16;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Write-port bundle: pipeline writeback, load returns, gr[] write port, hazard/status.
interface rf_wport_arbiter_if import cpu_pkg::*; #(
  parameter int DW = DW_DEF
);
  logic             wb_we;
  logic [GR_AW-1:0] wb_addr;
  logic [DW-1:0]    wb_data;
  logic             ld_valid;
  logic             ld_ready;
  logic [GR_AW-1:0] ld_addr;
  logic [DW-1:0]    ld_data;
  logic             rf_we;
  logic [GR_AW-1:0] rf_addr;
  logic [DW-1:0]    rf_data;
  logic [NGR-1:0]   pend_mask;
  logic             wb_stall;
  logic             err;

  modport master (
    output wb_we, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
    input  ld_ready, rf_we, rf_addr, rf_data, pend_mask, wb_stall, err
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
    output ld_ready, rf_we, rf_addr, rf_data, pend_mask, wb_stall, err
  );
endinterface

// File: rtl/rf_wq.sv
// Circular load-return queue; each entry carries addr, data and a live bit that WB can kill.
module rf_wq import cpu_pkg::*; #(
  parameter int DW     = DW_DEF,
  parameter int QDEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [GR_AW-1:0] push_addr,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [GR_AW-1:0] kill_addr,
  output logic [GR_AW-1:0] head_addr,
  output logic [DW-1:0]    head_data,
  output logic             head_live,
  output logic             full,
  output logic             empty,
  output logic [NGR-1:0]   live_mask
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [PW-1:0]    rptr, wptr;
  logic [PW:0]      count;
  logic [QDEPTH-1:0] live_q;
  logic [GR_AW-1:0] addr_q [QDEPTH];
  logic [DW-1:0]    data_q [QDEPTH];

  assign full      = (count == (PW+1)'(QDEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_q[rptr];
  assign head_data = data_q[rptr];
  assign head_live = live_q[rptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A same-cycle WB to the pushed address is program-newer, so the new entry starts dead.
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && wptr == PW'(i))
          live_q[i] <= !(kill_en && push_addr == kill_addr);
        else if (pop && rptr == PW'(i))
          live_q[i] <= 1'b0;
        else if (kill_en && addr_q[i] == kill_addr)
          live_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wptr] <= push_addr;
      data_q[wptr] <= push_data;
    end
  end

  always_comb begin
    live_mask = '0;
    for (int i = 0; i < QDEPTH; i++)
      if (live_q[i]) live_mask[addr_q[i]] = 1'b1;
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// Single gr[] write-port arbiter: pipeline WB has priority, queued load returns drain in gaps.
module rf_wport_arbiter import cpu_pkg::*; #(
  parameter int DW         = DW_DEF,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic state,
  rf_wport_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic             exec_on, q_full, q_empty, push, pop, wb_go, stall;
  logic [GR_AW-1:0] head_addr;
  logic [DW-1:0]    head_data;
  logic             head_live;
  logic [NGR-1:0]   live_mask;
  logic [CW-1:0]    starve_cnt;
  logic             rf_we_p1, err_q;
  logic [GR_AW-1:0] rf_addr_p1;
  logic [DW-1:0]    rf_data_p1;

  assign exec_on = (cpu_state_e'(state) == exec);
  assign wb_go   = exec_on & bus.wb_we;
  assign pop     = exec_on & ~bus.wb_we & ~q_empty;
  assign stall   = exec_on & ((starve_cnt == STARVE_LIM) | q_full);
  assign push    = bus.ld_valid & bus.ld_ready;

  assign bus.ld_ready  = exec_on & ~q_full;
  assign bus.wb_stall  = stall;
  assign bus.pend_mask = live_mask;
  assign bus.rf_we     = rf_we_p1;
  assign bus.rf_addr   = rf_addr_p1;
  assign bus.rf_data   = rf_data_p1;
  assign bus.err       = err_q;

  rf_wq #(.DW(DW), .QDEPTH(QDEPTH)) u_wq (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.ld_addr),
    .push_data (bus.ld_data),
    .pop       (pop),
    .kill_en   (wb_go),
    .kill_addr (bus.wb_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_live (head_live),
    .full      (q_full),
    .empty     (q_empty),
    .live_mask (live_mask)
  );

  // p1: registered gr[] write port, starve counter and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we_p1   <= 1'b0;
      rf_addr_p1 <= '0;
      rf_data_p1 <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else if (exec_on) begin
      rf_we_p1 <= wb_go | (pop & head_live);
      if (wb_go) begin
        rf_addr_p1 <= bus.wb_addr;
        rf_data_p1 <= bus.wb_data;
      end else if (pop && head_live) begin
        rf_addr_p1 <= head_addr;
        rf_data_p1 <= head_data;
      end
      if (pop)
        starve_cnt <= '0;
      else if (!q_empty && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
      if (wb_go && stall) err_q <= 1'b1;
    end else begin
      rf_we_p1 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized and directed bench for rf_wport_arbiter against a queue-based reference model.
module tb_rf_wport_arbiter;
  localparam int DW = 16;
  localparam int QDEPTH = 2;
  localparam int STARVE_MAX = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic state = 1'b0;

  rf_wport_arbiter_if #(.DW(DW)) bus ();

  rf_wport_arbiter #(.DW(DW), .QDEPTH(QDEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .state (state),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]    a;
    logic [DW-1:0] d;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  bit            m_we, m_err;
  logic [2:0]    m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt;
  logic [DW-1:0] m_gr [8];
  logic [DW-1:0] d_gr [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_err = 0; m_addr = '0; m_data = '0; m_cnt = 0;
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  // One clock of the specified arbitration rules, applied to the model's pre-edge state.
  task automatic model_step(input bit st, input bit we, input logic [2:0] wa, input logic [DW-1:0] wd,
                            input bit lv, input logic [2:0] la, input logic [DW-1:0] ldd);
    int  sz;
    bit  full, stall, popped;
    ent_t e;
    if (!st) begin
      m_we = 0;
      return;
    end
    sz = mq.size();
    full = (sz == QDEPTH);
    stall = (m_cnt == STARVE_MAX) || full;
    popped = 0;
    if (we) begin
      if (stall) m_err = 1;
      m_we = 1; m_addr = wa; m_data = wd;
      foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 0;
    end else if (sz > 0) begin
      e = mq.pop_front();
      popped = 1;
      m_we = e.live;
      if (e.live) begin m_addr = e.a; m_data = e.d; end
    end else begin
      m_we = 0;
    end
    if (lv && !full) mq.push_back('{a: la, d: ldd, live: !(we && la == wa)});
    if (popped) m_cnt = 0;
    else if (sz > 0 && m_cnt < STARVE_MAX) m_cnt++;
  endtask

  task automatic compare_all();
    bit full = (mq.size() == QDEPTH);
    check_eq("rf_we", bus.rf_we, m_we);
    if (m_we) begin
      check_eq("rf_addr", bus.rf_addr, m_addr);
      check_eq("rf_data", bus.rf_data, m_data);
    end
    check_eq("pend_mask", bus.pend_mask, model_pend());
    check_eq("ld_ready", bus.ld_ready, state && !full);
    check_eq("wb_stall", bus.wb_stall, state && ((m_cnt == STARVE_MAX) || full));
    check_eq("err", bus.err, m_err);
    if (bus.rf_we) d_gr[bus.rf_addr] = bus.rf_data;
    if (m_we) m_gr[m_addr] = m_data;
  endtask

  task automatic cycle(input bit st, input bit we, input int wa, input int wd,
                       input bit lv, input int la, input int ldd);
    state = st;
    bus.wb_we = we; bus.wb_addr = 3'(wa); bus.wb_data = DW'(wd);
    bus.ld_valid = lv; bus.ld_addr = 3'(la); bus.ld_data = DW'(ldd);
    model_step(st, we, 3'(wa), DW'(wd), lv, 3'(la), DW'(ldd));
    @(negedge clock);
    compare_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    state = 1'b0;
    #1;
    check_eq("rst_rf_we", bus.rf_we, 0);
    check_eq("rst_rf_addr", bus.rf_addr, 0);
    check_eq("rst_rf_data", bus.rf_data, 0);
    check_eq("rst_pend", bus.pend_mask, 0);
    check_eq("rst_stall", bus.wb_stall, 0);
    check_eq("rst_err", bus.err, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0;
    model_reset();
    for (int i = 0; i < 8; i++) begin m_gr[i] = '0; d_gr[i] = '0; end
    repeat (2) @(negedge clock);
    async_reset();

    // WB only
    cycle(1, 1, 3, 'h1234, 0, 0, 0);
    check_eq("wb_only_we", bus.rf_we, 1);
    check_eq("wb_only_addr", bus.rf_addr, 3);
    check_eq("wb_only_data", bus.rf_data, 'h1234);
    check_eq("wb_only_pend", bus.pend_mask, 0);

    // Load into idle port: mask in N+1, write in N+2
    cycle(1, 0, 0, 0, 1, 5, 'hBEEF);
    check_eq("ld_pend", bus.pend_mask, 'h20);
    check_eq("ld_no_bypass", bus.rf_we, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("ld_we", bus.rf_we, 1);
    check_eq("ld_addr", bus.rf_addr, 5);
    check_eq("ld_data", bus.rf_data, 'hBEEF);
    check_eq("ld_pend_clr", bus.pend_mask, 0);

    // Kill: queued ld to gr2 overtaken by WB gr2=7
    cycle(1, 1, 6, 'h0666, 1, 2, 'h5555);
    check_eq("kill_pend_pre", bus.pend_mask, 'h04);
    cycle(1, 1, 2, 'h0007, 0, 0, 0);
    check_eq("kill_pend_post", bus.pend_mask, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("kill_pop_we", bus.rf_we, 0);
    check_eq("kill_gr2", d_gr[2], 'h0007);

    // Starvation, then drained cleanly
    cycle(1, 1, 4, 'h0044, 1, 1, 'h1111);
    for (int i = 0; i < 3; i++) cycle(1, 1, 4, 'h0044 + i, 0, 0, 0);
    check_eq("starve_pre", bus.wb_stall, 0);
    cycle(1, 1, 4, 'h0050, 0, 0, 0);
    check_eq("starve_on", bus.wb_stall, 1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("starve_drain", bus.rf_addr, 1);
    check_eq("starve_off", bus.wb_stall, 0);
    check_eq("starve_err0", bus.err, 0);

    // Starvation with WB ignoring the stall
    cycle(1, 1, 4, 'h0060, 1, 1, 'h2222);
    for (int i = 0; i < 4; i++) cycle(1, 1, 4, 'h0061 + i, 0, 0, 0);
    cycle(1, 1, 7, 'h0777, 0, 0, 0);
    check_eq("err_set", bus.err, 1);
    check_eq("err_wb_kept", bus.rf_data, 'h0777);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("err_sticky", bus.err, 1);

    // Full queue
    @(negedge clock);
    async_reset();
    cycle(1, 1, 0, 'h0100, 1, 1, 'hA001);
    cycle(1, 1, 0, 'h0101, 1, 2, 'hA002);
    check_eq("full_ready", bus.ld_ready, 0);
    check_eq("full_stall", bus.wb_stall, 1);
    cycle(1, 0, 0, 0, 1, 3, 'hA003);
    check_eq("full_refused", bus.pend_mask, 'h04);
    cycle(1, 0, 0, 0, 1, 3, 'hA003);
    check_eq("full_accept", bus.pend_mask, 'h08);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Reset with two queued entries, then idle behaviour
    cycle(1, 1, 5, 'h0200, 1, 4, 'hB004);
    cycle(1, 1, 5, 'h0201, 1, 6, 'hB006);
    check_eq("prerst_pend", bus.pend_mask, 'h50);
    async_reset();
    cycle(0, 1, 3, 'h0300, 1, 1, 'hC001);
    check_eq("idle_no_we", bus.rf_we, 0);
    check_eq("idle_no_ready", bus.ld_ready, 0);
    check_eq("idle_pend", bus.pend_mask, 0);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7),
            $urandom_range(0, 16'hFFFF), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 16'hFFFF));
    end
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("gr%0d", i), d_gr[i], m_gr[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
